// File: rtl/sseg_pkg.sv
// sseg_pkg: shared glyph constants, controller states and helpers for the 7-segment display block.
package sseg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_FORMAT} state_t;
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000 + 1;
  endfunction
  // Active-low {g,f,e,d,c,b,a} codes for one hex nibble.
  function automatic logic [6:0] seg_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction
endpackage

// File: rtl/sseg_bin2bcd.sv
// sseg_bin2bcd: sequential double-dabble, one shift per cycle; done_o marks the cycle whose
// closing edge performs the final shift, so bcd_o is valid from the following cycle.
module sseg_bin2bcd
  import sseg_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int BCD_W  = bcd_digits(DATA_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [DATA_W-1:0]    bin_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [4*BCD_W-1:0]   bcd_o
);
  localparam int CW = $clog2(DATA_W + 1);
  logic [4*BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
  logic [DATA_W-1:0]  bin_q, bin_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < BCD_W; k++)
      bcd_adj[4*k+:4] = bcd_q[4*k+:4] >= 4'd5 ? bcd_q[4*k+:4] + 4'd3 : bcd_q[4*k+:4];
    bcd_d = bcd_q;
    bin_d = bin_q;
    cnt_d = cnt_q;
    if (start_i) begin
      bcd_d = '0;
      bin_d = bin_i;
      cnt_d = CW'(DATA_W);
    end else if (cnt_q != '0) begin
      {bcd_d, bin_d} = {bcd_adj[4*BCD_W-2:0], bin_q, 1'b0};
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
    end else begin
      bcd_q <= bcd_d;
      bin_q <= bin_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy_o = cnt_q != '0;
  assign done_o = cnt_q == CW'(1);
  assign bcd_o  = bcd_q;
endmodule

// File: rtl/sseg_multi_display.sv
// sseg_multi_display: captures a binary value, converts it (hex or decimal with sign),
// formats blanking/sign/overflow into a registered active-low segment pattern.
module sseg_multi_display
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [DATA_W-1:0]       value,
  input  logic                    hex_mode,
  input  logic                    signed_mode,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] segs
);
  localparam int BCD_W = bcd_digits(DATA_W);
  localparam int HEX_W = (DATA_W + 3) / 4;
  localparam int NT_A  = BCD_W > HEX_W ? BCD_W : HEX_W;
  localparam int NT    = NT_A > NUM_DIGITS ? NT_A : NUM_DIGITS;
  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       val_q, val_d, mag;
  logic                    hex_q, hex_d, neg_q, neg_d, blz_q, blz_d;
  logic                    done_q, done_d, ovf_q, ovf_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d, fmt;
  logic                    fmt_ovf, start, conv_busy, conv_done;
  logic [4*BCD_W-1:0]      bcd;
  logic [4*NT-1:0]         num;
  int                      msd, spos;
  assign start = state_q == S_IDLE && load && !hex_mode;
  assign mag   = signed_mode && value[DATA_W-1] ? -value : value;
  sseg_bin2bcd #(.DATA_W(DATA_W), .BCD_W(BCD_W)) u_bcd (
    .clk(clk), .rst_n(rst_n), .start_i(start), .bin_i(mag),
    .busy_o(conv_busy), .done_o(conv_done), .bcd_o(bcd)
  );
  // Hex and BCD digits share one zero-padded digit vector so the formatter is mode-agnostic.
  always_comb begin
    num = hex_q ? (4*NT)'(val_q) : (4*NT)'(bcd);
    msd = 0;
    for (int i = 0; i < NT; i++)
      if (num[4*i+:4] != 4'd0) msd = i;
    fmt_ovf = (msd + 1 + (neg_q ? 1 : 0)) > NUM_DIGITS;
    spos = blz_q ? msd + 1 : NUM_DIGITS - 1;
    fmt = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      fmt[7*i+:7] = fmt_ovf ? SEG_E :
                    (neg_q && i == spos) ? SEG_MINUS :
                    (blz_q && i > msd) ? SEG_BLANK : seg_glyph(num[4*i+:4]);
  end
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    hex_d   = hex_q;
    neg_d   = neg_q;
    blz_d   = blz_q;
    seg_d   = seg_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE && load) begin
      state_d = hex_mode ? S_FORMAT : S_CONV;
      val_d   = value;
      hex_d   = hex_mode;
      neg_d   = !hex_mode && signed_mode && value[DATA_W-1];
      blz_d   = blank_lz;
    end
    if (state_q == S_CONV && (conv_done || !conv_busy)) state_d = S_FORMAT;
    if (state_q == S_FORMAT) begin
      state_d = S_IDLE;
      seg_d   = fmt;
      ovf_d   = fmt_ovf;
      done_d  = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      hex_q   <= 1'b0;
      neg_q   <= 1'b0;
      blz_q   <= 1'b0;
      seg_q   <= '1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      hex_q   <= hex_d;
      neg_q   <= neg_d;
      blz_q   <= blz_d;
      seg_q   <= seg_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy     = state_q != S_IDLE;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign segs     = enable ? seg_q : '1;
endmodule

// File: tb/tb_sseg_multi_display.sv
// tb_sseg_multi_display: directed steps with a scoreboard of expected patterns popped on done.
module tb_sseg_multi_display;
  logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0;
  logic [19:0] value = '0;
  logic        hex_mode = 1'b0, signed_mode = 1'b0, blank_lz = 1'b0, enable = 1'b1;
  logic        busy, done, overflow;
  logic [41:0] segs, last_segs;
  int          n_cmp = 0, n_bad = 0;
  typedef struct {
    string       tag;
    logic [41:0] segs;
    logic        ovf;
    int          lat;
  } exp_t;
  exp_t sb[$];
  localparam logic [41:0] ALL_E = {6{7'h06}};
  sseg_multi_display #(.NUM_DIGITS(6), .DATA_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .hex_mode(hex_mode),
    .signed_mode(signed_mode), .blank_lz(blank_lz), .enable(enable),
    .busy(busy), .done(done), .overflow(overflow), .segs(segs)
  );
  always #5 clk = ~clk;
  function automatic logic [41:0] p6(input logic [6:0] a5, a4, a3, a2, a1, a0);
    return {a5, a4, a3, a2, a1, a0};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [19:0] v, input logic hx, sg, bz,
                     input logic [41:0] es, input logic eo, input int inj);
    exp_t e;
    int   got, n;
    @(negedge clk);
    value = v; hex_mode = hx; signed_mode = sg; blank_lz = bz; load = 1'b1;
    sb.push_back('{tag, es, eo, hx ? 1 : 21});
    got = 0;
    for (int c = 0; c < 60 && got == 0; c++) begin
      @(negedge clk);
      load = (c == inj);
      if (done) begin
        e = sb.pop_front();
        chk({e.tag, "_segs"}, 64'(segs), 64'(e.segs));
        chk({e.tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
        chk({e.tag, "_latency"}, 64'(c), 64'(e.lat));
        last_segs = e.segs;
        got = 1;
      end
    end
    load = 1'b0;
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    if (inj >= 0) begin
      n = 0;
      repeat (30) begin
        @(negedge clk);
        if (done) n++;
      end
      chk({tag, "_no_extra_done"}, 64'(n), 64'd0);
    end
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_segs", 64'(segs), {22'd0, 42'h3FF_FFFF_FFFF});
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    run("hex_blz1", 20'h0A3F5, 1, 0, 1, p6(7'h7F, 7'h7F, 7'h08, 7'h30, 7'h0E, 7'h12), 0, -1);
    run("hex_blz0", 20'h0A3F5, 1, 0, 0, p6(7'h40, 7'h40, 7'h08, 7'h30, 7'h0E, 7'h12), 0, -1);
    run("dec_neg1234", 20'(-1234), 0, 1, 1, p6(7'h7F, 7'h3F, 7'h79, 7'h24, 7'h30, 7'h19), 0, -1);
    run("dec_max_ovf", 20'd1048575, 0, 0, 1, ALL_E, 1, -1);
    // Reset during an active conversion: blank pattern, no late done.
    @(negedge clk);
    value = 20'd777; hex_mode = 0; signed_mode = 0; blank_lz = 1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_segs", 64'(segs), {22'd0, 42'h3FF_FFFF_FFFF});
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("midrst_no_done", 64'(n), 64'd0);
    run("dec_1e6_ovf", 20'd1000000, 0, 0, 0, ALL_E, 1, -1);
    run("dec_zero", 20'd0, 0, 0, 1, p6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40), 0, -1);
    run("dec_neg99999", 20'(-99999), 0, 1, 0, p6(7'h3F, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10), 0, -1);
    run("dec_minneg_ovf", 20'h80000, 0, 1, 1, ALL_E, 1, -1);
    run("dec_999999", 20'd999999, 0, 0, 1, {6{7'h10}}, 0, -1);
    run("hex_signed_raw", 20'hFFB2E, 1, 1, 1, p6(7'h7F, 7'h0E, 7'h0E, 7'h03, 7'h24, 7'h06), 0, -1);
    run("midload_ignored", 20'd42, 0, 0, 1, p6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24), 0, 5);
    run("load_at_done", 20'h00012, 1, 0, 1, p6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24), 0, 0);
    @(negedge clk);
    enable = 1'b0;
    #1 chk("enable_off", 64'(segs), {22'd0, 42'h3FF_FFFF_FFFF});
    enable = 1'b1;
    #1 chk("enable_restore", 64'(segs), 64'(last_segs));
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
